// File: rtl/sccb_pkg.sv
// Shared SCCB slave definitions: FSM state encoding, R/W bit values and the default device address.
package sccb_pkg;

    typedef enum logic [3:0] {
        IDLE,
        DEV,
        ACK_DEV,
        SUB,
        ACK_SUB,
        WDATA,
        ACK_WR,
        RDATA,
        MACK
    } sccb_state_t;

    localparam logic       SCCB_WR_BIT   = 1'b0;
    localparam logic       SCCB_RD_BIT   = 1'b1;
    localparam logic [6:0] SCCB_DEV_ADDR = 7'h21;

endpackage

// File: rtl/sccb_in_filter.sv
// Bus input conditioner: 2-flop synchronizer followed by a glitch filter that only accepts a
// new level after FILT_LEN consecutive equal samples. Resets to the idle-bus level (1).
module sccb_in_filter #(
    parameter int unsigned FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_filt
);

    localparam int unsigned CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_filt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
            r_cnt  <= '0;
            r_filt <= 1'b1;
        end else begin
            r_sync <= {r_sync[0], i_async};
            // Any sample matching the accepted level restarts the run of differing samples.
            if (r_sync[1] == r_filt) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(FILT_LEN - 1)) begin
                r_filt <= r_sync[1];
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_filt = r_filt;

endmodule

// File: rtl/sccb_slave_regfile.sv
// SCCB slave front-end for an 8-bit register file: device match, sub-address, burst write/read.
// Optional macro SCCB_SLAVE_AUTOINC_EN: reg_addr auto-increments after each written/ACKed read byte.
module sccb_slave_regfile
    import sccb_pkg::*;
#(
    parameter logic [6:0]  DEV_ADDR = SCCB_DEV_ADDR,
    parameter int unsigned FILT_LEN = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    sccb_state_t r_state, w_state_nxt;

    logic       w_scl_f, w_sda_f;
    logic       r_scl_d, r_sda_d;
    logic       w_scl_rise, w_scl_fall, w_start, w_stop;
    logic [3:0] r_bitcnt, w_bitcnt_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [7:0] w_byte;
    logic       r_sda_oe, w_oe_nxt;
    logic [7:0] r_addr, w_addr_nxt;
    logic [7:0] r_wdata, w_wdata_nxt;
    logic       r_we, w_we_nxt;
    logic       r_busy, w_busy_nxt;
    logic       r_rw, w_rw_nxt;

    sccb_in_filter #(.FILT_LEN(FILT_LEN)) u_scl_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (scl_i),
        .o_filt  (w_scl_f)
    );

    sccb_in_filter #(.FILT_LEN(FILT_LEN)) u_sda_filt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (sda_i),
        .o_filt  (w_sda_f)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_scl_d <= 1'b1;
            r_sda_d <= 1'b1;
        end else begin
            r_scl_d <= w_scl_f;
            r_sda_d <= w_sda_f;
        end
    end

    assign w_scl_rise = w_scl_f & ~r_scl_d;
    assign w_scl_fall = ~w_scl_f & r_scl_d;
    assign w_start    = w_scl_f & r_scl_d & r_sda_d & ~w_sda_f;
    assign w_stop     = w_scl_f & r_scl_d & ~r_sda_d & w_sda_f;
    assign w_byte     = {r_shift[6:0], w_sda_f};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    // ACK phases: the first SCL fall drives the ACK, the 9th rise wraps the bit counter 8->0,
    // and the following fall leaves the ACK state (loading read data when a read follows).
    always_comb begin
        w_state_nxt  = r_state;
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_oe_nxt     = r_sda_oe;
        w_addr_nxt   = r_addr;
        w_wdata_nxt  = r_wdata;
        w_we_nxt     = 1'b0;
        w_busy_nxt   = r_busy;
        w_rw_nxt     = r_rw;

        if (w_stop) begin
            w_state_nxt  = IDLE;
            w_oe_nxt     = 1'b0;
            w_busy_nxt   = 1'b0;
            w_bitcnt_nxt = '0;
        end else if (w_start) begin
            w_state_nxt  = DEV;
            w_oe_nxt     = 1'b0;
            w_bitcnt_nxt = '0;
        end else begin
            case (r_state)
                DEV, SUB, WDATA: begin
                    if (w_scl_rise) begin
                        w_shift_nxt  = w_byte;
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                        if (r_bitcnt == 4'd7) begin
                            case (r_state)
                                DEV: begin
                                    if (w_byte[7:1] == DEV_ADDR) begin
                                        w_state_nxt = ACK_DEV;
                                        w_rw_nxt    = w_byte[0];
                                        w_busy_nxt  = 1'b1;
                                    end else begin
                                        w_state_nxt = IDLE;
                                        w_busy_nxt  = 1'b0;
                                    end
                                end
                                SUB: begin
                                    w_addr_nxt  = w_byte;
                                    w_state_nxt = ACK_SUB;
                                end
                                default: begin
                                    w_wdata_nxt = w_byte;
                                    w_we_nxt    = 1'b1;
                                    w_state_nxt = ACK_WR;
                                end
                            endcase
                        end
                    end
                end

                ACK_DEV, ACK_SUB, ACK_WR: begin
                    if (w_scl_rise) begin
                        w_bitcnt_nxt = '0;
                    end else if (w_scl_fall) begin
                        if (r_bitcnt == 4'd8) begin
                            w_oe_nxt = 1'b1;
                        end else begin
                            w_oe_nxt = 1'b0;
                            case (r_state)
                                ACK_DEV: begin
                                    if (r_rw == SCCB_RD_BIT) begin
                                        w_state_nxt = RDATA;
                                        w_shift_nxt = reg_rdata;
                                        w_oe_nxt    = ~reg_rdata[7];
                                    end else begin
                                        w_state_nxt = SUB;
                                    end
                                end
                                ACK_SUB: w_state_nxt = WDATA;
                                default: begin
                                    w_state_nxt = WDATA;
`ifdef SCCB_SLAVE_AUTOINC_EN
                                    w_addr_nxt  = r_addr + 8'd1;
`endif
                                end
                            endcase
                        end
                    end
                end

                RDATA: begin
                    if (w_scl_rise) begin
                        w_bitcnt_nxt = r_bitcnt + 4'd1;
                        w_shift_nxt  = {r_shift[6:0], 1'b0};
                    end else if (w_scl_fall) begin
                        if (r_bitcnt == 4'd8) begin
                            w_oe_nxt    = 1'b0;
                            w_state_nxt = MACK;
                        end else begin
                            w_oe_nxt = ~r_shift[7];
                        end
                    end
                end

                MACK: begin
                    if (w_scl_rise) begin
                        w_bitcnt_nxt = '0;
                        if (w_sda_f) begin
                            w_state_nxt = IDLE;
                        end else begin
`ifdef SCCB_SLAVE_AUTOINC_EN
                            w_addr_nxt = r_addr + 8'd1;
`endif
                        end
                    end else if (w_scl_fall && r_bitcnt == 4'd0) begin
                        // reg_rdata has settled on the new address long before this fall.
                        w_state_nxt = RDATA;
                        w_shift_nxt = reg_rdata;
                        w_oe_nxt    = ~reg_rdata[7];
                    end
                end

                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_sda_oe <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_we     <= 1'b0;
            r_busy   <= 1'b0;
            r_rw     <= 1'b0;
        end else begin
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_sda_oe <= w_oe_nxt;
            r_addr   <= w_addr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_we     <= w_we_nxt;
            r_busy   <= w_busy_nxt;
            r_rw     <= w_rw_nxt;
        end
    end

    assign sda_oe    = r_sda_oe;
    assign reg_addr  = r_addr;
    assign reg_wdata = r_wdata;
    assign reg_we    = r_we;
    assign busy      = r_busy;

endmodule

// File: tb/tb_sccb_slave_regfile.sv
// Self-checking bench for sccb_slave_regfile: bit-banged SCCB master, emulated register file,
// and a transaction-level reference memory for expected writes and read data.
module tb_sccb_slave_regfile;
    import sccb_pkg::*;

    localparam int unsigned Q = 10;
    localparam logic [7:0] WR_BYTE = {SCCB_DEV_ADDR, SCCB_WR_BIT};
    localparam logic [7:0] RD_BYTE = {SCCB_DEV_ADDR, ~SCCB_WR_BIT};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       glitch = 1'b0;
    logic       scl_i, sda_i;
    logic       sda_oe, reg_we, busy;
    logic [7:0] reg_addr, reg_wdata, reg_rdata;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic [7:0]  wbytes  [$];
    logic [15:0] we_q    [$];
    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned we_len_err = 0;
    int unsigned oe_cnt = 0;
    logic        we_prev = 1'b0;

    always #5 clk = ~clk;

    assign scl_i     = scl_m ^ glitch;
    assign sda_i     = sda_m & ~sda_oe;
    assign reg_rdata = mem[reg_addr];

    sccb_slave_regfile #(.DEV_ADDR(7'h21), .FILT_LEN(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_oe    (sda_oe),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    // Register-file emulation plus write/ACK observers.
    always @(negedge clk) begin
        if (reg_we) begin
            we_q.push_back({reg_addr, reg_wdata});
            mem[reg_addr] = reg_wdata;
        end
        if (reg_we && we_prev) we_len_err++;
        we_prev = reg_we;
        if (sda_oe) oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input logic glt);
        sda_m = b;
        if (glt) begin
            tick(Q / 2);
            glitch = 1'b1;
            tick(1);
            glitch = 1'b0;
            tick(Q - Q / 2 - 1);
        end else begin
            tick(Q);
        end
        scl_m = 1'b1;
        tick(2 * Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic recv_bit(output logic b);
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        b = sda_i;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic bus_start();
        sda_m = 1'b1;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b0;
        tick(Q);
    endtask

    task automatic bus_stop();
        sda_m = 1'b0;
        tick(Q);
        scl_m = 1'b1;
        tick(Q);
        sda_m = 1'b1;
        tick(2 * Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input int glt, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) send_bit(d[i], glt == i);
        recv_bit(b);
        ack = ~b;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic b;
        d = '0;
        for (int i = 0; i < 8; i++) begin
            recv_bit(b);
            d = {d[6:0], b};
        end
        send_bit(~mack, 1'b0);
    endtask

    task automatic do_write(input logic [7:0] sub, input int glt, input string tag);
        logic        ack;
        logic [7:0]  ptr;
        int unsigned nack;
        nack = 0;
        ptr  = sub;
        we_q.delete();
        bus_start();
        write_byte(WR_BYTE, -1, ack);
        if (ack) nack++;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        write_byte(sub, -1, ack);
        if (ack) nack++;
        foreach (wbytes[i]) begin
            write_byte(wbytes[i], (i == 0) ? glt : -1, ack);
            if (ack) nack++;
        end
        bus_stop();
        check({tag, "_acks"}, nack, 32'(wbytes.size() + 2));
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_oe_end"}, 32'(sda_oe), 32'd0);
        check({tag, "_nwe"}, 32'(we_q.size()), 32'(wbytes.size()));
        foreach (wbytes[i]) begin
            if (i < we_q.size()) check({tag, "_we"}, 32'(we_q[i]), 32'({ptr, wbytes[i]}));
            ref_mem[ptr] = wbytes[i];
`ifdef SCCB_SLAVE_AUTOINC_EN
            ptr = ptr + 8'd1;
`endif
        end
    endtask

    task automatic do_read(input logic [7:0] sub, input int unsigned n, input string tag);
        logic        ack;
        logic [7:0]  ptr, d;
        int unsigned nack;
        nack = 0;
        ptr  = sub;
        we_q.delete();
        bus_start();
        write_byte(WR_BYTE, -1, ack);
        if (ack) nack++;
        write_byte(sub, -1, ack);
        if (ack) nack++;
        bus_start();
        write_byte(RD_BYTE, -1, ack);
        if (ack) nack++;
        check({tag, "_acks"}, nack, 32'd3);
        for (int unsigned i = 0; i < n; i++) begin
            read_byte(i + 1 < n, d);
            check({tag, "_rd"}, 32'(d), 32'(ref_mem[ptr]));
`ifdef SCCB_SLAVE_AUTOINC_EN
            ptr = ptr + 8'd1;
`endif
        end
        check({tag, "_oe_nack"}, 32'(sda_oe), 32'd0);
        bus_stop();
        check({tag, "_busy_end"}, 32'(busy), 32'd0);
        check({tag, "_nwe"}, 32'(we_q.size()), 32'd0);
    endtask

    initial begin
        logic       ack;
        logic [7:0] d;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end

        // Reset values, held and after release.
        tick(5);
        check("rst_oe", 32'(sda_oe), 32'd0);
        check("rst_addr", 32'(reg_addr), 32'd0);
        check("rst_wdata", 32'(reg_wdata), 32'd0);
        check("rst_we", 32'(reg_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        tick(10);
        check("post_rst_oe", 32'(sda_oe), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Single write.
        wbytes = '{8'h04};
        do_write(8'h12, -1, "wr_basic");

        // Sub-address write then repeated-start read with NACK.
        mem[8'h1C]     = 8'h7F;
        ref_mem[8'h1C] = 8'h7F;
        do_read(8'h1C, 1, "rd_basic");

        // Burst write across the top of the address space.
        wbytes = '{8'hAA, 8'hBB};
        do_write(8'hFF, -1, "wr_wrap");

        // Randomised writes and reads.
        for (int t = 0; t < 5; t++) begin
            wbytes.delete();
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) wbytes.push_back(8'($urandom));
            do_write(8'($urandom), -1, "wr_rand");
            do_read(8'($urandom), $urandom_range(1, 3), "rd_rand");
        end

        // Wrong device addresses are ignored.
        for (int t = 0; t < 3; t++) begin
            if (t == 0) d = 8'h60;
            else begin
                do d = 8'($urandom); while (d[7:1] == SCCB_DEV_ADDR);
            end
            we_q.delete();
            oe_cnt = 0;
            bus_start();
            write_byte(d, -1, ack);
            check("nodev_ack", 32'(ack), 32'd0);
            write_byte(8'h12, -1, ack);
            check("nodev_ack2", 32'(ack), 32'd0);
            check("nodev_oe_cycles", oe_cnt, 32'd0);
            bus_stop();
            check("nodev_nwe", 32'(we_q.size()), 32'd0);
            check("nodev_busy", 32'(busy), 32'd0);
        end

        // STOP after four data bits: partial byte dropped.
        we_q.delete();
        bus_start();
        write_byte(WR_BYTE, -1, ack);
        write_byte(8'h33, -1, ack);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        bus_stop();
        check("part_nwe", 32'(we_q.size()), 32'd0);
        check("part_busy", 32'(busy), 32'd0);
        check("part_oe", 32'(sda_oe), 32'd0);

        // One-clock SCL glitch inside a data byte must not add a bit.
        wbytes = '{8'h5A};
        do_write(8'h40, 4, "glitch");
        do_read(8'h40, 1, "glitch_rb");

        // Reset while the slave is driving ACK; SDA must release without a clock edge.
        bus_start();
        d = WR_BYTE;
        for (int i = 7; i >= 0; i--) send_bit(d[i], 1'b0);
        sda_m = 1'b1;
        check("ackslot_oe", 32'(sda_oe), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_rst_oe", 32'(sda_oe), 32'd0);
        scl_m = 1'b1;
        tick(10);
        rst_n = 1'b1;
        tick(10);
        check("rst2_addr", 32'(reg_addr), 32'd0);
        check("rst2_busy", 32'(busy), 32'd0);
        scl_m = 1'b0;
        tick(Q);
        write_byte(WR_BYTE, -1, ack);
        check("nostart_ack", 32'(ack), 32'd0);
        bus_stop();
        wbytes = '{8'hC3};
        do_write(8'h07, -1, "after_rst");

        check("we_width", we_len_err, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sccb_slave_regfile.md
SCCB_SLAVE_REGFILE -- requirements
Module: sccb_slave_regfile

Interface
REQ-001 Parameter DEV_ADDR, 7'h21, 7-bit device address; write byte is 0x42, read byte is 0x43.
REQ-002 Parameter FILT_LEN, 3, number of consecutive equal samples required to accept a new SCL/SDA level.
REQ-003 Port clk, input, 1, system clock; shall be at least 20x the SCL rate.
REQ-004 Port rst_n, input, 1, asynchronous active-low reset.
REQ-005 Port scl_i, input, 1, SCCB clock from the bus; asynchronous to clk.
REQ-006 Port sda_i, input, 1, SCCB data from the bus; asynchronous to clk.
REQ-007 Port sda_oe, output, 1, 1 = pull SDA low (open-drain); 0 = release SDA.
REQ-008 Port reg_addr, output, 8, current sub-address.
REQ-009 Port reg_wdata / reg_we, output, 8/1, write data plus a one-cycle write strobe.
REQ-010 Port reg_rdata, input, 8, read data for reg_addr; combinational, valid in the cycle after reg_addr changes.
REQ-011 Port busy, output, 1, high from an addressed START until STOP.

Function
REQ-012 scl_i and sda_i shall pass through a 2-flop synchronizer, then a FILT_LEN-sample filter; all logic uses the filtered levels scl_f and sda_f.
REQ-013 START = sda_f falls while scl_f is high; STOP = sda_f rises while scl_f is high; both are detected 1 cycle after the filtered edge.
REQ-014 Bits shall be sampled on the rising edge of scl_f, MSB first; sda_oe changes only on the falling edge of scl_f.
REQ-015 FSM states: IDLE, DEV, ACK_DEV, SUB, ACK_SUB, WDATA, ACK_WR, RDATA, MACK.
REQ-016 IDLE → DEV on START. In DEV, after 8 bits:
- byte[7:1]==DEV_ADDR → ACK_DEV (drive sda_oe=1 for the 9th SCL);
- otherwise → IDLE with no ACK.
REQ-017 ACK_DEV exit:
- R/W=0 → SUB;
- R/W=1 → RDATA, with the byte at the current reg_addr loaded for shifting.
REQ-018 SUB captures 8 bits into reg_addr → ACK_SUB → WDATA.
REQ-019 WDATA, after 8 bits: drive reg_wdata, pulse reg_we for exactly 1 clk on the 8th rising SCL edge → ACK_WR → WDATA.
REQ-020 RDATA: sda_oe = ~bit for each of 8 bits, then release SDA → MACK.
- Master ACK (sda_f=0 at SCL rise) → RDATA with the next byte.
- NACK → IDLE.
REQ-021 A STOP in any state shall go to IDLE, release sda_oe, and clear busy; reg_addr is retained.
REQ-022 A repeated START in any non-IDLE state shall go to DEV with the bit counter cleared; reg_addr is retained, so a write-sub-address-then-read sequence works.
REQ-023 A START or STOP seen mid-byte shall abort that byte; no reg_we shall be issued for a partial byte.
REQ-024 Bit counter is 4 bits and wraps 8→0 at each ACK phase.

Reset
REQ-025 While rst_n=0, and after rst_n rises, the block shall present:
- state=IDLE, sda_oe=0, reg_addr=0, reg_wdata=0, reg_we=0, busy=0;
- synchronizer and filter outputs=1 (bus idle).
REQ-026 Reset asserted mid-transfer shall release SDA asynchronously; the next transfer is recognised only after a fresh START.

Configuration
REQ-027 Macro SCCB_SLAVE_AUTOINC_EN.
- Defined: reg_addr increments (mod 256) after each written byte in ACK_WR, and after each read byte at MACK.
- Undefined: reg_addr stays fixed; repeated bytes rewrite or re-read the same register.

Structure
REQ-028 Package sccb_pkg holds:
- the FSM state enum;
- constants SCCB_WR_BIT=0 and SCCB_RD_BIT=1;
- the default DEV_ADDR.
REQ-029 Sub-module sccb_in_filter (synchronizer plus glitch filter) is instantiated twice, for SCL and SDA.

Verification
REQ-030 Write 0x42, sub 0x12, data 0x04, STOP: reg_we pulses once with reg_addr=0x12 and reg_wdata=0x04; sda_oe=1 during all three ACK slots.
REQ-031 Read: write 0x42 + sub 0x1C, repeated START, 0x43 with reg_rdata=0x7F, master NACK: 0x7F appears on SDA MSB first, then state=IDLE.
REQ-032 Device byte 0x60: no ACK, no reg_we, sda_oe stays 0 until STOP.
REQ-033 Burst write to 0xFF of data 0xAA then 0xBB:
- with the macro defined: writes land at 0xFF then 0x00;
- without it: both writes land at 0xFF.
REQ-034 STOP after 4 data bits: no reg_we, busy falls, sda_oe=0.
REQ-035 1-clk glitch on SCL with FILT_LEN=3: no bit is sampled; rst_n low while sda_oe=1 drops sda_oe to 0 immediately.
